// File: rtl/int_priority_ctrl_pkg.sv
// Shared constants, state encoding and vector helper for the interrupt
// priority controller.
package int_priority_ctrl_pkg;

    localparam logic [5:0] NMI_LSBS_DEF = 6'h3E;
    localparam logic [5:0] TOP_LSBS_DEF = 6'h3D;
    localparam int         IDX_W        = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    // Vector LSBs count down from the top vector as the source index rises.
    function automatic logic [5:0] src_lsbs(input logic [5:0] top, input logic [IDX_W-1:0] idx);
        return top - {2'b00, idx};
    endfunction

endpackage

// File: rtl/int_prio_encoder.sv
// Combinational priority encoder: lowest set request index wins.
module int_prio_encoder
    import int_priority_ctrl_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // Scan from the top down so the lowest active index is the last one written.
    always_comb begin
        valid = |req;
        index = {IDX_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            index = req[i] ? IDX_W'(i) : index;
        end
    end

endmodule

// File: rtl/int_priority_ctrl.sv
// Interrupt scheduler: edge-captures requests, arbitrates NMI over maskable
// sources, freezes the vector through INTACK and pulses a clear to the winner.
module int_priority_ctrl
    import int_priority_ctrl_pkg::*;
#(
    parameter int         NUM_SRC  = 16,
    parameter logic [5:0] NMI_LSBS = NMI_LSBS_DEF,
    parameter logic [5:0] TOP_LSBS = TOP_LSBS_DEF
) (
    input  logic               MCLK,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [NUM_SRC-1:0] irq_en,
    input  logic               nmi_in,
    input  logic               INTACK,
    output logic               NMI,
    output logic               INT,
    output logic [5:0]         IntAddrLSBs,
    output logic [NUM_SRC-1:0] irq_clr,
    output logic               busy
);

    state_t             state_r, state_s;
    logic [NUM_SRC-1:0] irq_prev_r, pend_r;
    logic               nmi_prev_r, nmi_pend_r;
    logic               ack_start_s, win_valid_s, nmi_clr_s, nmi_keep_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic [NUM_SRC-1:0] win_onehot_s, src_clr_s, pend_kept_s;
    logic [5:0]         lsbs_s;

    int_prio_encoder #(.N(NUM_SRC)) u_enc (
        .req   (pend_r & irq_en),
        .valid (win_valid_s),
        .index (win_idx_s)
    );

    // FSM next state; only the IDLE->ACK transition services a source.
    always_comb begin
        state_s     = state_r;
        ack_start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (INTACK) begin
                    state_s     = ST_ACK;
                    ack_start_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (INTACK) begin
                    state_s = ST_ACK;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Winner clear masks; NMI takes the acknowledge ahead of any maskable source.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            win_onehot_s[i] = (win_idx_s == IDX_W'(i));
        end
        nmi_clr_s   = ack_start_s & nmi_pend_r;
        src_clr_s   = (ack_start_s && !nmi_pend_r && win_valid_s) ? win_onehot_s : {NUM_SRC{1'b0}};
        pend_kept_s = pend_r & ~src_clr_s;
        nmi_keep_s  = nmi_pend_r & ~nmi_clr_s;
    end

    // Vector selection; held in ACK and when nothing is requesting.
    always_comb begin
        if (state_r == ST_IDLE) begin
            if (nmi_pend_r) begin
                lsbs_s = NMI_LSBS;
            end else if (win_valid_s) begin
                lsbs_s = src_lsbs(TOP_LSBS, win_idx_s);
            end else begin
                lsbs_s = IntAddrLSBs;
            end
        end else begin
            lsbs_s = IntAddrLSBs;
        end
    end

    // State, pending and output registers; a new edge beats a same-cycle clear.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            irq_prev_r  <= {NUM_SRC{1'b0}};
            pend_r      <= {NUM_SRC{1'b0}};
            nmi_prev_r  <= 1'b0;
            nmi_pend_r  <= 1'b0;
            NMI         <= 1'b0;
            INT         <= 1'b0;
            IntAddrLSBs <= NMI_LSBS;
            irq_clr     <= {NUM_SRC{1'b0}};
            busy        <= 1'b0;
        end else begin
            state_r     <= state_s;
            irq_prev_r  <= irq_in;
            pend_r      <= pend_kept_s | (irq_in & ~irq_prev_r);
            nmi_prev_r  <= nmi_in;
            nmi_pend_r  <= nmi_keep_s | (nmi_in & ~nmi_prev_r);
            NMI         <= nmi_keep_s;
            INT         <= |(pend_kept_s & irq_en);
            IntAddrLSBs <= lsbs_s;
            irq_clr     <= src_clr_s;
            busy        <= (state_s == ST_ACK);
        end
    end

endmodule

// File: tb/tb_int_priority_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic compared
// against a cycle-level behavioural model of the scheduler.
module tb_int_priority_ctrl;

    logic        MCLK;
    logic        reset;
    logic [15:0] irq_in, irq_en, irq_clr;
    logic        nmi_in, INTACK, NMI, INT, busy;
    logic [5:0]  IntAddrLSBs;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state and expected outputs
    logic [15:0] m_pend, m_prev, e_clr;
    logic        m_npend, m_nprev, m_ack, e_nmi, e_int, e_busy;
    logic [5:0]  e_lsbs;

    logic [15:0] r_irq, r_en;
    logic        r_nmi, r_ack, r_rst;

    int_priority_ctrl dut (
        .MCLK        (MCLK),
        .reset       (reset),
        .irq_in      (irq_in),
        .irq_en      (irq_en),
        .nmi_in      (nmi_in),
        .INTACK      (INTACK),
        .NMI         (NMI),
        .INT         (INT),
        .IntAddrLSBs (IntAddrLSBs),
        .irq_clr     (irq_clr),
        .busy        (busy)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advances the model by one clock edge seeing the given inputs.
    task automatic model_update(input logic [15:0] irq, input logic [15:0] en,
                                input logic nmi, input logic ack, input logic rst);
        logic [15:0] enabled;
        int          k;
        if (rst) begin
            m_pend = 16'h0; m_prev = 16'h0; m_npend = 1'b0; m_nprev = 1'b0; m_ack = 1'b0;
            e_nmi = 1'b0; e_int = 1'b0; e_lsbs = 6'h3E; e_clr = 16'h0; e_busy = 1'b0;
        end else begin
            enabled = m_pend & en;
            k = -1;
            for (int i = 0; i < 16; i++) begin
                if (enabled[i] && k < 0) k = i;
            end
            e_clr = 16'h0;
            if (!m_ack) begin
                if (m_npend) e_lsbs = 6'h3E;
                else if (k >= 0) e_lsbs = 6'(61 - k);
                if (ack) begin
                    if (m_npend) m_npend = 1'b0;
                    else if (k >= 0) begin
                        m_pend[k] = 1'b0;
                        e_clr[k]  = 1'b1;
                    end
                end
            end
            e_nmi   = m_npend;
            e_int   = |(m_pend & en);
            e_busy  = ack;
            m_ack   = ack;
            m_pend  = m_pend | (irq & ~m_prev);
            m_npend = m_npend | (nmi & ~m_nprev);
            m_prev  = irq;
            m_nprev = nmi;
        end
    endtask

    task automatic step(input logic [15:0] irq, input logic [15:0] en,
                        input logic nmi, input logic ack, input logic rst);
        irq_in = irq; irq_en = en; nmi_in = nmi; INTACK = ack; reset = rst;
        model_update(irq, en, nmi, ack, rst);
        @(posedge MCLK);
        #1;
        check_val("nmi",  32'(NMI),         32'(e_nmi));
        check_val("int",  32'(INT),         32'(e_int));
        check_val("lsbs", 32'(IntAddrLSBs), 32'(e_lsbs));
        check_val("clr",  32'(irq_clr),     32'(e_clr));
        check_val("busy", 32'(busy),        32'(e_busy));
    endtask

    initial begin
        irq_in = 16'h0; irq_en = 16'h0; nmi_in = 1'b0; INTACK = 1'b0; reset = 1'b1;
        step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        check_val("rst_lsbs", 32'(IntAddrLSBs), 32'h3E);
        check_val("rst_int",  32'(INT),         32'h0);

        // 1: single source 3
        step(16'h0000, 16'h0008, 1'b0, 1'b0, 1'b0);
        step(16'h0008, 16'h0008, 1'b0, 1'b0, 1'b0);
        step(16'h0008, 16'h0008, 1'b0, 1'b0, 1'b0);
        check_val("t1_int",  32'(INT),         32'h1);
        check_val("t1_lsbs", 32'(IntAddrLSBs), 32'h3A);
        step(16'h0008, 16'h0008, 1'b0, 1'b1, 1'b0);
        check_val("t1_clr",  32'(irq_clr), 32'h0008);
        check_val("t1_drop", 32'(INT),     32'h0);
        step(16'h0008, 16'h0008, 1'b0, 1'b1, 1'b0);
        check_val("t1_clr_once", 32'(irq_clr), 32'h0);
        step(16'h0008, 16'h0008, 1'b0, 1'b1, 1'b0);
        step(16'h0008, 16'h0008, 1'b0, 1'b0, 1'b0);

        // 2: sources 2 and 5 together
        step(16'h0024, 16'h0024, 1'b0, 1'b0, 1'b0);
        step(16'h0024, 16'h0024, 1'b0, 1'b0, 1'b0);
        check_val("t2_first", 32'(IntAddrLSBs), 32'h3B);
        step(16'h0024, 16'h0024, 1'b0, 1'b1, 1'b0);
        check_val("t2_clr", 32'(irq_clr), 32'h0004);
        step(16'h0024, 16'h0024, 1'b0, 1'b0, 1'b0);
        step(16'h0024, 16'h0024, 1'b0, 1'b0, 1'b0);
        check_val("t2_second", 32'(IntAddrLSBs), 32'h38);
        check_val("t2_int",    32'(INT),         32'h1);
        step(16'h0024, 16'h0024, 1'b0, 1'b1, 1'b0);
        step(16'h0024, 16'h0024, 1'b0, 1'b0, 1'b0);

        // 3: NMI over pending source 0
        step(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
        step(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
        step(16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0);
        step(16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0);
        check_val("t3_nmi",  32'(NMI),         32'h1);
        check_val("t3_lsbs", 32'(IntAddrLSBs), 32'h3E);
        step(16'h0001, 16'h0001, 1'b1, 1'b1, 1'b0);
        check_val("t3_nmi_drop", 32'(NMI),     32'h0);
        check_val("t3_no_clr",   32'(irq_clr), 32'h0);
        step(16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0);
        step(16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0);
        check_val("t3_next", 32'(IntAddrLSBs), 32'h3D);
        step(16'h0001, 16'h0001, 1'b1, 1'b1, 1'b0);
        step(16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0);

        // 4: masked source 1
        step(16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0);
        step(16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_val("t4_masked", 32'(INT), 32'h0);
        step(16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0);
        check_val("t4_int",  32'(INT),         32'h1);
        check_val("t4_lsbs", 32'(IntAddrLSBs), 32'h3C);
        step(16'h0002, 16'h0002, 1'b0, 1'b1, 1'b0);
        step(16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0);

        // 5: fresh edge on source 4 in the acknowledge cycle
        step(16'h0010, 16'h0010, 1'b0, 1'b0, 1'b0);
        step(16'h0010, 16'h0010, 1'b0, 1'b0, 1'b0);
        check_val("t5_lsbs", 32'(IntAddrLSBs), 32'h39);
        step(16'h0000, 16'h0010, 1'b0, 1'b0, 1'b0);
        step(16'h0010, 16'h0010, 1'b0, 1'b1, 1'b0);
        check_val("t5_clr", 32'(irq_clr), 32'h0010);
        step(16'h0010, 16'h0010, 1'b0, 1'b0, 1'b0);
        check_val("t5_int", 32'(INT), 32'h1);
        step(16'h0010, 16'h0010, 1'b0, 1'b0, 1'b0);
        step(16'h0010, 16'h0010, 1'b0, 1'b1, 1'b0);
        step(16'h0010, 16'h0010, 1'b0, 1'b0, 1'b0);

        // 6: reset during ACK
        step(16'h0000, 16'h0011, 1'b0, 1'b0, 1'b0);
        step(16'h0011, 16'h0011, 1'b0, 1'b0, 1'b0);
        step(16'h0011, 16'h0011, 1'b0, 1'b0, 1'b0);
        step(16'h0011, 16'h0011, 1'b0, 1'b1, 1'b0);
        step(16'h0011, 16'h0011, 1'b0, 1'b1, 1'b1);
        check_val("t6_busy", 32'(busy),        32'h0);
        check_val("t6_int",  32'(INT),         32'h0);
        check_val("t6_lsbs", 32'(IntAddrLSBs), 32'h3E);
        step(16'h0000, 16'h0011, 1'b0, 1'b0, 1'b0);
        check_val("t6_discard", 32'(INT), 32'h0);

        // Random traffic
        r_irq = 16'h0; r_en = 16'hFFFF; r_nmi = 1'b0; r_ack = 1'b0; r_rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            r_irq = r_irq ^ 16'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) r_en = 16'($urandom);
            if ($urandom_range(0, 7) == 0) r_nmi = ~r_nmi;
            if ($urandom_range(0, 3) == 0) r_ack = ~r_ack;
            r_rst = ($urandom_range(0, 199) == 0);
            step(r_irq, r_en, r_nmi, r_ack, r_rst);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
